// File: rtl/cpu_control_pkg.sv
// Shared CPU definitions: instruction field sizes, opcode encodings,
// register-file write-source encodings and the controller state type.
package cpu_pkg;

  localparam int cpu_inst_opcode_sz = 4;
  localparam int cpu_inst_regop_sz  = 3;
  localparam int cpu_inst_immop_sz  = 8;
  localparam int cpu_code_sz        = 256;
  localparam int cpu_pc_sz          = 9;

  localparam logic [3:0] cpu_inst_opcode_add = 4'd0;
  localparam logic [3:0] cpu_inst_opcode_sub = 4'd1;
  localparam logic [3:0] cpu_inst_opcode_mul = 4'd2;
  localparam logic [3:0] cpu_inst_opcode_div = 4'd3;
  localparam logic [3:0] cpu_inst_opcode_and = 4'd4;
  localparam logic [3:0] cpu_inst_opcode_or  = 4'd5;
  localparam logic [3:0] cpu_inst_opcode_xor = 4'd6;
  localparam logic [3:0] cpu_inst_opcode_inc = 4'd7;
  localparam logic [3:0] cpu_inst_opcode_dec = 4'd8;
  localparam logic [3:0] cpu_inst_opcode_imm = 4'd9;
  localparam logic [3:0] cpu_inst_opcode_iz  = 4'd10;
  localparam logic [3:0] cpu_inst_opcode_jmp = 4'd11;
  localparam logic [3:0] cpu_inst_opcode_jz  = 4'd12;
  localparam logic [3:0] cpu_inst_opcode_out = 4'd13;
  localparam logic [3:0] cpu_inst_opcode_imp = 4'd14;

  localparam logic [1:0] cpu_wsel_alu = 2'd0;
  localparam logic [1:0] cpu_wsel_imm = 2'd1;
  localparam logic [1:0] cpu_wsel_in  = 2'd2;

  typedef enum logic [2:0] {
    EXEC     = 3'd0,
    WAIT_ALU = 3'd1,
    WAIT_IN  = 3'd2,
    WAIT_OUT = 3'd3,
    HALT     = 3'd4
  } cpu_state_t;

endpackage

// File: rtl/cpu_control_inst_len.sv
// Opcode -> instruction length in bits plus a legal-opcode flag.
// Purely combinational; shared with the assembler checks.
module cpu_inst_len
  import cpu_pkg::*;
#(
  parameter int OPSZ = cpu_inst_opcode_sz,
  parameter int RGSZ = cpu_inst_regop_sz,
  parameter int IMSZ = cpu_inst_immop_sz,
  parameter int PCSZ = cpu_pc_sz
) (
  input  logic [OPSZ-1:0] opcode,
  output logic [PCSZ:0]   len,
  output logic            legal
);

  localparam int LW = PCSZ + 1;
  localparam logic [PCSZ:0] LEN_JMP = LW'(OPSZ + IMSZ);
  localparam logic [PCSZ:0] LEN_IMM = LW'(OPSZ + RGSZ + IMSZ);
  localparam logic [PCSZ:0] LEN_R1  = LW'(OPSZ + RGSZ);
  localparam logic [PCSZ:0] LEN_R2  = LW'(OPSZ + 2 * RGSZ);

  // Length lookup; unknown encodings report illegal with zero length
  always_comb begin
    len   = '0;
    legal = 1'b1;
    case (opcode)
      cpu_inst_opcode_jmp, cpu_inst_opcode_jz: len = LEN_JMP;
      cpu_inst_opcode_imm: len = LEN_IMM;
      cpu_inst_opcode_out, cpu_inst_opcode_imp, cpu_inst_opcode_iz,
      cpu_inst_opcode_inc, cpu_inst_opcode_dec: len = LEN_R1;
      cpu_inst_opcode_add, cpu_inst_opcode_sub, cpu_inst_opcode_mul,
      cpu_inst_opcode_div, cpu_inst_opcode_and, cpu_inst_opcode_or,
      cpu_inst_opcode_xor: len = LEN_R2;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// CPU sequencing controller: pc, strobes, branching, zero flag, fault halt.
// Optional single-step gating of EXEC via the CPU_CONTROL_STEP_EN macro.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int OPSZ   = cpu_inst_opcode_sz,
  parameter int RGSZ   = cpu_inst_regop_sz,
  parameter int IMSZ   = cpu_inst_immop_sz,
  parameter int CODESZ = cpu_code_sz,
  parameter int PCSZ   = cpu_pc_sz
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CPU_CONTROL_STEP_EN
  input  logic            step,
`endif
  input  logic [OPSZ-1:0] opcode,
  input  logic [IMSZ-1:0] immop1,
  input  logic            rz,
  input  logic            alu_done,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic [PCSZ-1:0] pc,
  output logic            reg_we,
  output logic [1:0]      wsel,
  output logic            alu_start,
  output logic            in_ready,
  output logic            out_valid,
  output logic            zflag,
  output logic            halted,
  output logic            fault
);

  localparam int LW = PCSZ + 1;
  localparam logic [PCSZ:0] CODE_END = LW'(CODESZ);

  cpu_state_t      state_r, state_s;
  logic [PCSZ-1:0] pc_r, pc_s;
  logic            zflag_r, zflag_s;
  logic            fault_r, fault_s;
  logic [PCSZ:0]   len_s;
  logic            legal_s;
  logic [PCSZ:0]   pc_adv_s;
  logic [PCSZ-1:0] target_s;
  logic [PCSZ:0]   target_end_s;
  logic            overrun_s;
  logic            target_bad_s;
  logic            issue_s;

  cpu_inst_len #(.OPSZ(OPSZ), .RGSZ(RGSZ), .IMSZ(IMSZ), .PCSZ(PCSZ)) u_len (
    .opcode (opcode),
    .len    (len_s),
    .legal  (legal_s)
  );

  // Range checks are done one bit wider than pc so nothing can wrap
  assign pc_adv_s     = {1'b0, pc_r} + len_s;
  assign overrun_s    = (pc_adv_s > CODE_END);
  assign target_s     = PCSZ'(immop1);
  assign target_end_s = {1'b0, target_s} + LW'(OPSZ);
  assign target_bad_s = (target_end_s > CODE_END);

`ifdef CPU_CONTROL_STEP_EN
  assign issue_s = step;
`else
  assign issue_s = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EXEC;
      pc_r    <= '0;
      zflag_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      zflag_r <= zflag_s;
      fault_r <= fault_s;
    end
  end

  // Next-state, pc and flag update
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    zflag_s = zflag_r;
    fault_s = fault_r;
    case (state_r)
      EXEC: begin
        if (!issue_s) begin
          state_s = EXEC;
        end else if (!legal_s || overrun_s) begin
          state_s = HALT;
          fault_s = 1'b1;
        end else begin
          case (opcode)
            cpu_inst_opcode_jmp, cpu_inst_opcode_jz: begin
              if (opcode == cpu_inst_opcode_jz && !zflag_r) begin
                pc_s = pc_adv_s[PCSZ-1:0];
              end else if (target_bad_s) begin
                state_s = HALT;
                fault_s = 1'b1;
              end else begin
                pc_s = target_s;
              end
            end
            cpu_inst_opcode_iz: begin
              zflag_s = rz;
              pc_s    = pc_adv_s[PCSZ-1:0];
            end
            cpu_inst_opcode_mul, cpu_inst_opcode_div: state_s = WAIT_ALU;
            cpu_inst_opcode_imp: state_s = WAIT_IN;
            cpu_inst_opcode_out: state_s = WAIT_OUT;
            cpu_inst_opcode_imm, cpu_inst_opcode_inc, cpu_inst_opcode_dec,
            cpu_inst_opcode_add, cpu_inst_opcode_sub, cpu_inst_opcode_and,
            cpu_inst_opcode_or, cpu_inst_opcode_xor: pc_s = pc_adv_s[PCSZ-1:0];
            default: begin
              state_s = HALT;
              fault_s = 1'b1;
            end
          endcase
        end
      end
      WAIT_ALU, WAIT_IN, WAIT_OUT: begin
        if ((state_r == WAIT_ALU && alu_done) || (state_r == WAIT_IN && in_valid) ||
            (state_r == WAIT_OUT && out_ready)) begin
          pc_s    = pc_adv_s[PCSZ-1:0];
          state_s = EXEC;
        end else begin
          state_s = state_r;
        end
      end
      HALT: state_s = HALT;
      default: begin
        state_s = HALT;
        fault_s = 1'b1;
      end
    endcase
  end

  // Strobe decode; everything is quiet during reset and in HALT
  always_comb begin
    reg_we    = 1'b0;
    wsel      = cpu_wsel_alu;
    alu_start = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst) begin
      reg_we = 1'b0;
    end else begin
      case (state_r)
        EXEC: begin
          if (issue_s && legal_s && !overrun_s) begin
            case (opcode)
              cpu_inst_opcode_imm: begin
                reg_we = 1'b1;
                wsel   = cpu_wsel_imm;
              end
              cpu_inst_opcode_inc, cpu_inst_opcode_dec, cpu_inst_opcode_add,
              cpu_inst_opcode_sub, cpu_inst_opcode_and, cpu_inst_opcode_or,
              cpu_inst_opcode_xor: reg_we = 1'b1;
              cpu_inst_opcode_mul, cpu_inst_opcode_div: alu_start = 1'b1;
              default: reg_we = 1'b0;
            endcase
          end else begin
            reg_we = 1'b0;
          end
        end
        WAIT_ALU: reg_we = alu_done;
        WAIT_IN: begin
          in_ready = 1'b1;
          if (in_valid) begin
            reg_we = 1'b1;
            wsel   = cpu_wsel_in;
          end else begin
            reg_we = 1'b0;
          end
        end
        WAIT_OUT: out_valid = 1'b1;
        default: reg_we = 1'b0;
      endcase
    end
  end

  assign pc     = pc_r;
  assign zflag  = zflag_r;
  assign fault  = fault_r;
  assign halted = (state_r == HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Directed-vector bench for cpu_control with a queue-based scoreboard.
// Expected flags are packed {reg_we, wsel[1:0], alu_start, in_ready, out_valid, zflag, halted, fault}.
module tb_cpu_control;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic [7:0] immop1 = 8'd0;
  logic       rz = 1'b0, alu_done = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [8:0] pc;
  logic       reg_we, alu_start, in_ready, out_valid, zflag, halted, fault;
  logic [1:0] wsel;
`ifdef CPU_CONTROL_STEP_EN
  logic       step = 1'b1;
`endif

  typedef struct {
    string      name;
    logic [8:0] pc;
    logic [8:0] fl;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  localparam logic [8:0] F_NONE = 9'b0_00_000_000;
  localparam logic [8:0] F_WIMM = 9'b1_01_000_000;
  localparam logic [8:0] F_WALU = 9'b1_00_000_000;
  localparam logic [8:0] F_WIN  = 9'b1_10_010_000;
  localparam logic [8:0] F_STRT = 9'b0_00_100_000;
  localparam logic [8:0] F_OUT  = 9'b0_00_001_000;
  localparam logic [8:0] F_Z    = 9'b0_00_000_100;
  localparam logic [8:0] F_HALT = 9'b0_00_000_011;
  localparam logic [3:0] OP_BAD = 4'd15;

  cpu_control dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CPU_CONTROL_STEP_EN
    .step      (step),
`endif
    .opcode    (opcode),
    .immop1    (immop1),
    .rz        (rz),
    .alu_done  (alu_done),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .pc        (pc),
    .reg_we    (reg_we),
    .wsel      (wsel),
    .alu_start (alu_start),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .zflag     (zflag),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs just after the edge and queue what the DUT must show
  task automatic cyc(input string nm, input logic r, input logic [3:0] op, input logic [7:0] im,
                     input logic rzv, input logic ad, input logic iv, input logic orr,
                     input logic [8:0] e_pc, input logic [8:0] e_fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; immop1 = im; rz = rzv;
    alu_done = ad; in_valid = iv; out_ready = orr;
    e.name = nm; e.pc = e_pc; e.fl = e_fl;
    q.push_back(e);
  endtask

  // Monitor: pop and compare every cycle the scoreboard holds an expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {reg_we, wsel, alu_start, in_ready, out_valid, zflag, halted, fault};
      compared++;
      if (pc !== e.pc || act !== e.fl) begin
        mismatched++;
        $display("FAIL %s: got pc=%0d flags=%b, want pc=%0d flags=%b", e.name, pc, act, e.pc, e.fl);
      end
    end
  end

  initial begin
    //   name          rst op                  imm   rz ad iv or  pc   flags
    cyc("reset",       1, cpu_inst_opcode_imm, 8'd5, 0, 0, 0, 0, 9'd0,   F_NONE);
    cyc("imm",         0, cpu_inst_opcode_imm, 8'd5, 0, 0, 0, 0, 9'd0,   F_WIMM);
    cyc("add",         0, cpu_inst_opcode_add, 8'd0, 0, 0, 0, 0, 9'd15,  F_WALU);
    cyc("mul_start",   0, cpu_inst_opcode_mul, 8'd0, 0, 1, 0, 0, 9'd25,  F_STRT);
    cyc("mul_wait1",   0, cpu_inst_opcode_mul, 8'd0, 0, 0, 0, 0, 9'd25,  F_NONE);
    cyc("mul_wait2",   0, cpu_inst_opcode_mul, 8'd0, 0, 0, 0, 0, 9'd25,  F_NONE);
    cyc("mul_done",    0, cpu_inst_opcode_mul, 8'd0, 0, 1, 0, 0, 9'd25,  F_WALU);
    cyc("iz_rz1",      0, cpu_inst_opcode_iz,  8'd0, 1, 0, 0, 0, 9'd35,  F_NONE);
    cyc("jz_taken",    0, cpu_inst_opcode_jz,  8'd40,0, 0, 0, 0, 9'd42,  F_Z);
    cyc("iz_rz0",      0, cpu_inst_opcode_iz,  8'd0, 0, 0, 0, 0, 9'd40,  F_Z);
    cyc("jz_fall",     0, cpu_inst_opcode_jz,  8'd40,0, 0, 0, 0, 9'd47,  F_NONE);
    cyc("out_issue",   0, cpu_inst_opcode_out, 8'd0, 0, 0, 0, 0, 9'd59,  F_NONE);
    for (int i = 0; i < 4; i++)
      cyc("out_stall", 0, cpu_inst_opcode_out, 8'd0, 0, 0, 0, 0, 9'd59,  F_OUT);
    cyc("out_xfer",    0, cpu_inst_opcode_out, 8'd0, 0, 0, 0, 1, 9'd59,  F_OUT);
    cyc("imp_issue",   0, cpu_inst_opcode_imp, 8'd0, 0, 0, 1, 0, 9'd66,  F_NONE);
    cyc("imp_xfer",    0, cpu_inst_opcode_imp, 8'd0, 0, 0, 1, 0, 9'd66,  F_WIN);
    cyc("inc",         0, cpu_inst_opcode_inc, 8'd0, 0, 0, 0, 0, 9'd73,  F_WALU);
    cyc("div_start",   0, cpu_inst_opcode_div, 8'd0, 0, 0, 0, 0, 9'd80,  F_STRT);
    cyc("rst_in_wait", 1, cpu_inst_opcode_div, 8'd0, 0, 1, 0, 0, 9'd80,  F_NONE);
    cyc("jmp_250",     0, cpu_inst_opcode_jmp, 8'd250,0,0, 0, 0, 9'd0,   F_NONE);
    cyc("overrun",     0, cpu_inst_opcode_imm, 8'd0, 0, 0, 0, 0, 9'd250, F_NONE);
    cyc("halt1",       0, cpu_inst_opcode_add, 8'd0, 0, 0, 0, 0, 9'd250, F_HALT);
    cyc("halt2",       0, cpu_inst_opcode_add, 8'd0, 0, 1, 1, 1, 9'd250, F_HALT);
    cyc("halt_rst",    1, cpu_inst_opcode_add, 8'd0, 0, 0, 0, 0, 9'd250, F_HALT);
    cyc("illegal",     0, OP_BAD,              8'd0, 0, 0, 0, 0, 9'd0,   F_NONE);
    cyc("ill_halt",    0, cpu_inst_opcode_imm, 8'd0, 0, 0, 1, 0, 9'd0,   F_HALT);
    cyc("ill_rst",     1, cpu_inst_opcode_imm, 8'd0, 0, 0, 0, 0, 9'd0,   F_HALT);
    cyc("jmp_253",     0, cpu_inst_opcode_jmp, 8'd253,0,0, 0, 0, 9'd0,   F_NONE);
    cyc("tgt_halt",    1, cpu_inst_opcode_jmp, 8'd0, 0, 0, 0, 0, 9'd0,   F_HALT);
    cyc("jmp_246",     0, cpu_inst_opcode_jmp, 8'd246,0,0, 0, 0, 9'd0,   F_NONE);
    cyc("add_fits",    0, cpu_inst_opcode_add, 8'd0, 0, 0, 0, 0, 9'd246, F_WALU);
    cyc("inc_at_end",  0, cpu_inst_opcode_inc, 8'd0, 0, 0, 0, 0, 9'd256, F_NONE);
    cyc("end_halt",    0, cpu_inst_opcode_inc, 8'd0, 0, 0, 0, 0, 9'd256, F_HALT);
    cyc("end_rst",     1, cpu_inst_opcode_inc, 8'd0, 0, 0, 0, 0, 9'd256, F_HALT);
`ifdef CPU_CONTROL_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 10; i++)
      cyc("step_idle", 0, cpu_inst_opcode_imm, 8'd0, 0, 0, 0, 0, 9'd0,   F_NONE);
    cyc("step_one",    0, cpu_inst_opcode_imm, 8'd0, 0, 0, 0, 0, 9'd0,   F_WIMM);
    step = 1'b1;
    cyc("step_after",  0, cpu_inst_opcode_imm, 8'd0, 0, 0, 0, 0, 9'd15,  F_NONE);
    step = 1'b0;
    cyc("step_hold",   0, cpu_inst_opcode_imm, 8'd0, 0, 0, 0, 0, 9'd15,  F_NONE);
`endif
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Sequencing controller for the CPU core.
- Owns the program counter and steps it through the bit-addressed code image.
- Reads the decoded opcode and drives the control strobes for the register file, the multi-cycle ALU, the input port and the output port.
- Resolves jmp/jz branching, maintains the zero flag and halts on faults.

Parameters:
- OPSZ, cpu_inst_opcode_sz: opcode field width in bits.
- RGSZ, cpu_inst_regop_sz: register operand field width.
- IMSZ, cpu_inst_immop_sz: immediate operand field width.
- CODESZ, cpu_code_sz: code image size in bits.
- PCSZ, cpu_pc_sz: program counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  OPSZ  decoded opcode at the current pc (combinational from the decoder).
- immop1  input  IMSZ  decoded immediate; jump target for jmp/jz.
- rz  input  1  regop1 register value equals zero (from the register file).
- alu_done  input  1  multi-cycle ALU result valid (mul/div).
- in_valid  input  1  input port holds a word.
- out_ready  input  1  output port accepts a word.
- pc  output  PCSZ  current instruction bit address.
- reg_we  output  1  write regop1 this cycle.
- wsel  output  2  write source: 0=ALU, 1=immediate, 2=input port.
- alu_start  output  1  one-cycle pulse starting mul/div.
- in_ready  output  1  consume input word (imp).
- out_valid  output  1  offer regop1 to output port (out).
- zflag  output  1  zero flag.
- halted  output  1  controller stopped.
- fault  output  1  halt caused by an illegal opcode or a code overrun.

Behaviour:
- Reset: pc=0, zflag=0, halted=0, fault=0, state=EXEC. All strobes are 0 while rst is high. Reset mid-wait abandons the instruction with no write.
- Instruction length L, in bits:
  - jmp/jz: OPSZ+IMSZ.
  - imm: OPSZ+RGSZ+IMSZ.
  - out/imp/iz/inc/dec: OPSZ+RGSZ.
  - add/sub/mul/div/and/or/xor: OPSZ+2*RGSZ.
- Advance: pc_next = pc+L, computed at PCSZ+1 width. If pc+L > CODESZ, or a jump target + OPSZ > CODESZ, go to HALT with fault=1 and leave pc unchanged. There is no wrap-around.
- EXEC, single-cycle ops (imm, inc, dec, add, sub, and, or, xor):
  - reg_we=1 with the matching wsel, combinationally in this cycle.
  - pc<=pc+L at the edge.
  - Each op retires in exactly 1 cycle.
- EXEC, iz: zflag<=rz; pc<=pc+L; no write.
- EXEC, jmp: pc<=immop1 (zero-extended/truncated to PCSZ).
- EXEC, jz: if zflag, pc<=immop1; else pc<=pc+L. zflag is unchanged.
- EXEC, mul/div: alu_start=1 for one cycle, then go to WAIT_ALU.
  - WAIT_ALU: hold pc. When alu_done=1, assert reg_we (wsel=0), set pc<=pc+L, return to EXEC.
  - alu_done asserted in the same cycle as alu_start is ignored. Minimum latency is 2 cycles.
- EXEC, imp: go to WAIT_IN.
  - WAIT_IN: in_ready=1. Only when in_valid && in_ready: reg_we=1 (wsel=2), pc<=pc+L, return to EXEC.
  - If in_valid is already high on entry, the instruction completes in 2 cycles total.
- EXEC, out: go to WAIT_OUT.
  - WAIT_OUT: out_valid=1, held until out_ready. Once asserted it is never dropped before the transfer.
  - On the transfer: pc<=pc+L, return to EXEC.
- Illegal opcode: go to HALT with fault=1.
- HALT: halted=1, all strobes 0, pc frozen. Only rst exits HALT.
- zflag is written only by iz.

Optional Feature:
- Macro: CPU_CONTROL_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - EXEC only starts a new instruction in a cycle where step=1. With step=0 in EXEC, all strobes are 0 and pc holds.
  - Wait states ignore step.
- When undefined: no step port; EXEC issues every cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - the size constants cpu_inst_opcode_sz, cpu_inst_regop_sz, cpu_inst_immop_sz, cpu_code_sz, cpu_pc_sz;
  - every cpu_inst_opcode_* constant;
  - the wsel encodings;
  - the state enum typedef (EXEC, WAIT_ALU, WAIT_IN, WAIT_OUT, HALT).
- One combinational sub-module, cpu_inst_len: opcode -> L plus a legal flag. It is also reused by the assembler checks.

Test Plan:
- imm r1,5 at pc=0, then add r1,r2 -> reg_we=1 with wsel=1 at cycle 0; pc=OPSZ+RGSZ+IMSZ after one cycle; next cycle reg_we=1 with wsel=0; pc advances by OPSZ+2*RGSZ.
- mul with alu_done raised 3 cycles after alu_start -> alu_start pulses exactly once; pc constant for 3 cycles; reg_we=1 in the alu_done cycle only.
- iz with rz=1, then jz to target 40 -> zflag=1, pc=40. Repeat with rz=0 -> pc=pc+OPSZ+IMSZ.
- out with out_ready low for 4 cycles -> out_valid held 5 cycles; pc advances one cycle after the handshake. imp with in_valid already high -> completes in 2 cycles.
- Illegal opcode, and separately a final instruction overrunning CODESZ -> halted=1, fault=1, pc unchanged, strobes 0 until rst. rst asserted in WAIT_ALU -> pc=0, no reg_we.
- With CPU_CONTROL_STEP_EN: step=0 for 10 cycles -> pc frozen, no strobes; one step pulse -> exactly one instruction retires.
